// File: rtl/cheri_clu_wb_buffer_if.sv
// Bus between the CHERI unit, the writeback buffer and the scoreboard writeback port.
// The buffer uses the slave modport; the environment driving it uses master.
interface cheri_clu_wb_buffer_if #(
  parameter int CAP_W      = 160,
  parameter int XLEN       = 64,
  parameter int TRANS_ID_W = 3,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  flush_i;
  logic                  clu_valid_i;
  logic                  clu_ready_o;
  logic [CAP_W-1:0]      clu_result_i;
  logic [TRANS_ID_W-1:0] clu_trans_id_i;
  logic [XLEN-1:0]       clu_ex_cause_i;
  logic [XLEN-1:0]       clu_ex_tval_i;
  logic                  clu_ex_valid_i;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [CAP_W-1:0]      wb_result_o;
  logic [TRANS_ID_W-1:0] wb_trans_id_o;
  logic [XLEN-1:0]       wb_ex_cause_o;
  logic [XLEN-1:0]       wb_ex_tval_o;
  logic                  wb_ex_valid_o;
  logic [CNT_W-1:0]      count_o;
  logic                  overflow_o;

  modport slave (
    input  flush_i, clu_valid_i, clu_result_i, clu_trans_id_i,
           clu_ex_cause_i, clu_ex_tval_i, clu_ex_valid_i, wb_ready_i,
    output clu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o,
           wb_ex_cause_o, wb_ex_tval_o, wb_ex_valid_o, count_o, overflow_o
  );

  modport master (
    output flush_i, clu_valid_i, clu_result_i, clu_trans_id_i,
           clu_ex_cause_i, clu_ex_tval_i, clu_ex_valid_i, wb_ready_i,
    input  clu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o,
           wb_ex_cause_o, wb_ex_tval_o, wb_ex_valid_o, count_o, overflow_o
  );
endinterface

// File: rtl/cheri_clu_wb_buffer.sv
// In-order FIFO between the CHERI unit and the scoreboard writeback port.
// Head entry is presented combinationally; data outputs read as zero while empty.
module cheri_clu_wb_buffer #(
  parameter int CAP_W      = 160,
  parameter int XLEN       = 64,
  parameter int TRANS_ID_W = 3,
  parameter int DEPTH      = 4,
  parameter int TAG_IDX    = CAP_W - 1
) (
  input logic clk_i,
  input logic rst_i,
  cheri_clu_wb_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [CAP_W-1:0]      result;
    logic [TRANS_ID_W-1:0] trans_id;
    logic                  ex_valid;
    logic [XLEN-1:0]       cause;
    logic [XLEN-1:0]       tval;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry_s;
  entry_t           head_s;
  logic             wr_en_s;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full_s, valid_s, push_s, pop_s;
  logic [CAP_W-1:0] head_result_s;

  // Handshake qualification and next-state of pointers, occupancy and overflow.
  always_comb begin
    full_s     = (count_q == CNT_W'(DEPTH));
    valid_s    = (count_q != {CNT_W{1'b0}});
    push_s     = bus.clu_valid_i & ~full_s;
    pop_s      = valid_s & bus.wb_ready_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    if (bus.flush_i) begin
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      wr_en_s = push_s;
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
      if (bus.clu_valid_i & full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Entry image: exception fields are zeroed unless an exception was raised.
  always_comb begin
    wr_entry_s.result   = bus.clu_result_i;
    wr_entry_s.trans_id = bus.clu_trans_id_i;
    wr_entry_s.ex_valid = bus.clu_ex_valid_i;
    wr_entry_s.cause    = bus.clu_ex_cause_i & {XLEN{bus.clu_ex_valid_i}};
    wr_entry_s.tval     = bus.clu_ex_tval_i & {XLEN{bus.clu_ex_valid_i}};
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_entry_s;
    end
  end

  // Head presentation; a faulting result never carries a valid tag.
  always_comb begin
    head_s        = mem_q[rd_ptr_q];
    head_result_s = head_s.result;
    if (head_s.ex_valid) begin
      head_result_s[TAG_IDX] = 1'b0;
    end else begin
      head_result_s = head_s.result;
    end
    if (!valid_s) begin
      head_s        = '0;
      head_result_s = {CAP_W{1'b0}};
    end else begin
      head_s.result = head_result_s;
    end
  end

  assign bus.clu_ready_o   = ~full_s;
  assign bus.wb_valid_o    = valid_s;
  assign bus.wb_result_o   = head_result_s;
  assign bus.wb_trans_id_o = head_s.trans_id;
  assign bus.wb_ex_valid_o = head_s.ex_valid;
  assign bus.wb_ex_cause_o = head_s.cause;
  assign bus.wb_ex_tval_o  = head_s.tval;
  assign bus.count_o       = count_q;
  assign bus.overflow_o    = overflow_q;
endmodule

// File: tb/tb_cheri_clu_wb_buffer.sv
// Bench for cheri_clu_wb_buffer: table-driven steps checked against a queue scoreboard,
// plus hand sequences for concurrent traffic, flush and asynchronous reset.
module tb_cheri_clu_wb_buffer;
  localparam int CAP_W = 160;
  localparam int XLEN  = 64;
  localparam int TIDW  = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cheri_clu_wb_buffer_if #(.CAP_W(CAP_W), .XLEN(XLEN), .TRANS_ID_W(TIDW), .DEPTH(DEPTH)) bus ();
  cheri_clu_wb_buffer #(.CAP_W(CAP_W), .XLEN(XLEN), .TRANS_ID_W(TIDW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct {
    logic [CAP_W-1:0] res;
    logic [TIDW-1:0]  id;
    logic             ex;
    logic [XLEN-1:0]  cause;
    logic [XLEN-1:0]  tval;
  } exp_t;

  typedef struct {
    logic            v, rdy, fl, tag, ex;
    logic [TIDW-1:0] id;
    logic [XLEN-1:0] cause, tval;
    int              exp_cnt;
    logic            exp_ovf;
  } vec_t;

  exp_t sb[$];
  logic m_ovf;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [CAP_W-1:0] act, input logic [CAP_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CAP_W-1:0] mk_cap(input logic tag, input logic [TIDW-1:0] id);
    logic [CAP_W-1:0] c;
    c          = '0;
    c[CAP_W-1] = tag;
    c[63:0]    = 64'h0000_0000_8000_0000;
    c[95:64]   = {29'h0A5A5A5A, id};
    return c;
  endfunction

  task automatic check_outputs();
    chk("wb_valid", bus.wb_valid_o, sb.size() != 0);
    chk("clu_ready", bus.clu_ready_o, sb.size() != DEPTH);
    chk("count", bus.count_o, sb.size());
    chk("overflow", bus.overflow_o, m_ovf);
    if (sb.size() != 0) begin
      chk("wb_result", bus.wb_result_o, sb[0].res);
      chk("wb_id", bus.wb_trans_id_o, sb[0].id);
      chk("wb_ex_valid", bus.wb_ex_valid_o, sb[0].ex);
      chk("wb_cause", bus.wb_ex_cause_o, sb[0].cause);
      chk("wb_tval", bus.wb_ex_tval_o, sb[0].tval);
    end else begin
      chk("wb_result_idle", bus.wb_result_o, '0);
      chk("wb_id_idle", bus.wb_trans_id_o, '0);
      chk("wb_ex_idle", {bus.wb_ex_valid_o, bus.wb_ex_cause_o, bus.wb_ex_tval_o}, '0);
    end
  endtask

  // Drive one cycle, check the pre-edge outputs, update the scoreboard, then cross the edge.
  task automatic step(input logic v, input logic rdy, input logic fl, input logic tag,
                      input logic [TIDW-1:0] id, input logic ex,
                      input logic [XLEN-1:0] cause, input logic [XLEN-1:0] tval);
    exp_t e;
    logic full;
    logic do_pop;
    bus.clu_valid_i    = v;
    bus.wb_ready_i     = rdy;
    bus.flush_i        = fl;
    bus.clu_result_i   = mk_cap(tag, id);
    bus.clu_trans_id_i = id;
    bus.clu_ex_valid_i = ex;
    bus.clu_ex_cause_i = cause;
    bus.clu_ex_tval_i  = tval;
    check_outputs();
    full   = (sb.size() == DEPTH);
    do_pop = (sb.size() != 0) && rdy;
    e.res  = mk_cap(tag, id);
    if (ex) e.res[CAP_W-1] = 1'b0;
    e.id    = id;
    e.ex    = ex;
    e.cause = ex ? cause : 64'h0;
    e.tval  = ex ? tval : 64'h0;
    if (fl) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (v && full) m_ovf = 1'b1;
      if (do_pop) void'(sb.pop_front());
      if (v && !full) sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, rdy, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0);
  endtask

  function automatic vec_t mkv(input logic v, input logic rdy, input logic fl, input logic tag,
                               input logic [TIDW-1:0] id, input logic ex,
                               input logic [XLEN-1:0] cause, input logic [XLEN-1:0] tval,
                               input int exp_cnt, input logic exp_ovf);
    vec_t r;
    r.v = v; r.rdy = rdy; r.fl = fl; r.tag = tag; r.id = id; r.ex = ex;
    r.cause = cause; r.tval = tval; r.exp_cnt = exp_cnt; r.exp_ovf = exp_ovf;
    return r;
  endfunction

  vec_t tbl [16];

  initial begin
    // single push, fill/overflow/drain, flush, exception entry, no-exception masking
    tbl[0]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 64'h0, 64'h0, 1, 1'b0);
    tbl[1]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 0, 1'b0);
    tbl[2]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 64'h0, 64'h0, 1, 1'b0);
    tbl[3]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 64'h0, 64'h0, 2, 1'b0);
    tbl[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 64'h0, 64'h0, 3, 1'b0);
    tbl[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 64'h0, 64'h0, 4, 1'b0);
    tbl[6]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 64'h0, 64'h0, 4, 1'b1);
    tbl[7]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 3, 1'b1);
    tbl[8]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 2, 1'b1);
    tbl[9]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 1, 1'b1);
    tbl[10] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 0, 1'b1);
    tbl[11] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 0, 1'b0);
    tbl[12] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 64'h1C, 64'h1234, 1, 1'b0);
    tbl[13] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 0, 1'b0);
    tbl[14] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 64'hDEAD_BEEF_CAFE_F00D,
                  64'h0123_4567_89AB_CDEF, 1, 1'b0);
    tbl[15] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0, 64'h0, 0, 1'b0);

    m_ovf = 1'b0;
    rst   = 1'b1;
    bus.clu_valid_i = 1'b0; bus.wb_ready_i = 1'b0; bus.flush_i = 1'b0;
    bus.clu_result_i = '0; bus.clu_trans_id_i = '0; bus.clu_ex_valid_i = 1'b0;
    bus.clu_ex_cause_i = '0; bus.clu_ex_tval_i = '0;
    @(posedge clk);
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].rdy, tbl[i].fl, tbl[i].tag, tbl[i].id, tbl[i].ex,
           tbl[i].cause, tbl[i].tval);
      chk($sformatf("tbl%0d_count", i), bus.count_o, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_ovf", i), bus.overflow_o, tbl[i].exp_ovf);
    end

    // Concurrent push/pop at count 2 across pointer wrap.
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 64'h0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 64'h0, 64'h0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, k[0], 3'(k + 2), 1'b0, 64'h0, 64'h0);
      chk("steady_count", bus.count_o, 2);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 64'h0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 64'h0, 64'h0);
    chk("full_count", bus.count_o, 4);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 64'h0, 64'h0);
    chk("full_pop_push_count", bus.count_o, 3);

    // Flush coincident with a push at count 3.
    step(1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 64'h5, 64'h6);
    chk("flush_count", bus.count_o, 0);
    chk("flush_ovf", bus.overflow_o, 1'b0);
    idle(1'b1);

    // Asynchronous reset in the middle of a drain.
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 64'h0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 64'h7, 64'h8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 64'h0, 64'h0);
    idle(1'b1);
    check_outputs();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.wb_valid_o, 1'b0);
    chk("async_rst_count", bus.count_o, 0);
    chk("async_rst_ready", bus.clu_ready_o, 1'b1);
    chk("async_rst_id", bus.wb_trans_id_o, 0);
    sb.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 64'h0, 64'h0);
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
